// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU)
//   - FSM state enum
//   - mdu_iters(width, step): number of iteration cycles for a given
//     operand width and bits retired per cycle
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } mdu_state_e;

    function automatic int mdu_iters(input int width, input int step);
        return width / step;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of the MDU datapath.
//   i_is_div : 1 = restoring-divide step, 0 = shift-add multiply step
//   i_acc    : 2*WIDTH accumulator. MUL: {partial product, remaining
//              multiplier}. DIV: low half holds the dividend bits being
//              shifted out / quotient bits being shifted in.
//   i_rem    : WIDTH+1 partial remainder (DIV only, passed through on MUL)
//   i_opd    : multiplicand magnitude (MUL) or divisor magnitude (DIV)
//   o_acc    : accumulator after the step
//   o_rem    : partial remainder after the step
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic                 i_is_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH:0]       i_rem,
    input  logic [WIDTH-1:0]     i_opd,
    output logic [2*WIDTH-1:0]   o_acc,
    output logic [WIDTH:0]       o_rem
);

    localparam int PW = WIDTH + MUL_STEP;

    logic [MUL_STEP-1:0] w_mbits;
    logic [PW-1:0]       w_pp;
    logic [PW-1:0]       w_sum;
    logic [2*WIDTH-1:0]  w_mul_acc;
    logic [WIDTH:0]      w_trial;
    logic [WIDTH:0]      w_diff;
    logic                w_ge;
    logic [2*WIDTH-1:0]  w_div_acc;
    logic [WIDTH:0]      w_div_rem;
    // The remainder stays below the divisor, so its top bit is always zero
    // before the shift; it only exists to hold the shifted trial value.
    logic                w_unused_rem_msb;

    assign w_unused_rem_msb = i_rem[WIDTH];

    // Multiply: add multiplicand * next MUL_STEP multiplier bits into the
    // upper half, then shift the whole accumulator right by MUL_STEP. The
    // sum can never exceed WIDTH+MUL_STEP bits, so no carry is lost.
    assign w_mbits   = i_acc[MUL_STEP-1:0];
    assign w_pp      = PW'(i_opd) * PW'(w_mbits);
    assign w_sum     = PW'(i_acc[2*WIDTH-1:WIDTH]) + w_pp;
    assign w_mul_acc = {w_sum, i_acc[WIDTH-1:MUL_STEP]};

    // Restoring divide: bring in the next dividend bit, subtract the divisor
    // if it fits, shift the resulting quotient bit into the low end.
    assign w_trial   = {i_rem[WIDTH-1:0], i_acc[WIDTH-1]};
    assign w_diff    = w_trial - {1'b0, i_opd};
    assign w_ge      = (w_trial >= {1'b0, i_opd});
    assign w_div_rem = w_ge ? w_diff : w_trial;
    assign w_div_acc = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-2:0], w_ge};

    always_comb begin
        o_acc = w_mul_acc;
        o_rem = i_rem;
        if (i_is_div) begin
            o_acc = w_div_acc;
            o_rem = w_div_rem;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with flush, busy/done handshake
// and divide-by-zero reporting.
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_start, i_op      : request and operation (MULT/MULTU/DIV/DIVU)
//   i_a, i_b           : rs / rt operands, sampled on the accepting edge
//   i_flush            : abort; wins over i_start
//   o_busy             : high in MUL, DIV and FIX
//   o_done             : one-cycle pulse in DONE
//   o_hi, o_lo         : product halves, or remainder / quotient
//   o_div_zero         : last completed divide had a zero divisor
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_div_zero
);

    localparam int MUL_N = mdu_iters(WIDTH, MUL_STEP);
    localparam int DIV_N = mdu_iters(WIDTH, 1);
    localparam int CNT_W = $clog2(WIDTH + 1);

    mdu_state_e          r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_accept, w_is_mul_op, w_signed_op, w_b_zero;
    logic [WIDTH-1:0]    w_a_mag, w_b_mag;
    logic                r_is_div, r_dz, r_neg_res, r_neg_rem;
    logic [2*WIDTH-1:0]  r_acc, w_step_acc, w_prod;
    logic [WIDTH:0]      r_rem, w_step_rem;
    logic [WIDTH-1:0]    r_opd, w_quo, w_remw, w_res_hi, w_res_lo;
    logic [WIDTH-1:0]    r_hi, r_lo;
    logic                r_div_zero;
    logic                w_unused_rem_msb;

    assign w_accept    = (r_state == ST_IDLE || r_state == ST_DONE) && i_start && !i_flush;
    assign w_is_mul_op = (i_op == MDU_MULT) || (i_op == MDU_MULTU);
    assign w_signed_op = (i_op == MDU_MULT) || (i_op == MDU_DIV);
    assign w_b_zero    = (i_b == '0);
    // Unsigned magnitude; the most-negative value maps onto itself, which
    // is exactly its magnitude when read as unsigned.
    assign w_a_mag     = (w_signed_op && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_b_mag     = (w_signed_op && i_b[WIDTH-1]) ? -i_b : i_b;

    mdu_step #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_rem    (r_rem),
        .i_opd    (r_opd),
        .o_acc    (w_step_acc),
        .o_rem    (w_step_rem)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        if (i_flush) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (!i_start)         w_next = ST_IDLE;
                    else if (w_is_mul_op) w_next = ST_MUL;
                    else if (w_b_zero)    w_next = ST_FIX;
                    else                  w_next = ST_DIV;
                end
                ST_MUL:  if (r_cnt == CNT_W'(MUL_N - 1)) w_next = ST_FIX;
                ST_DIV:  if (r_cnt == CNT_W'(DIV_N - 1)) w_next = ST_FIX;
                ST_FIX:  w_next = ST_DONE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        o_busy = (r_state == ST_MUL) || (r_state == ST_DIV) || (r_state == ST_FIX);
        o_done = (r_state == ST_DONE);
    end

    // Iteration counter and per-operation control flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_dz      <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            if ((r_state == ST_MUL || r_state == ST_DIV) && w_next == r_state)
                r_cnt <= r_cnt + CNT_W'(1);
            else
                r_cnt <= '0;
            if (w_accept) begin
                r_is_div  <= !w_is_mul_op;
                r_dz      <= !w_is_mul_op && w_b_zero;
                r_neg_res <= w_signed_op && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                r_neg_rem <= w_signed_op && !w_is_mul_op && i_a[WIDTH-1];
            end
        end
    end

    // Datapath: operands loaded on accept, then stepped every MUL/DIV cycle.
    // On divide-by-zero r_opd keeps the raw dividend for the hi result.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_rem <= '0;
            if (w_is_mul_op) begin
                r_acc <= {{WIDTH{1'b0}}, w_b_mag};
                r_opd <= w_a_mag;
            end else if (w_b_zero) begin
                r_acc <= '0;
                r_opd <= i_a;
            end else begin
                r_acc <= {{WIDTH{1'b0}}, w_a_mag};
                r_opd <= w_b_mag;
            end
        end else if (r_state == ST_MUL || r_state == ST_DIV) begin
            r_acc <= w_step_acc;
            r_rem <= w_step_rem;
        end
    end

    // FIX-cycle sign correction and result selection
    assign w_unused_rem_msb = r_rem[WIDTH];
    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quo  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_remw = r_neg_rem ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_dz) begin
            w_res_hi = r_opd;
            w_res_lo = '1;
        end else if (r_is_div) begin
            w_res_hi = w_remw;
            w_res_lo = w_quo;
        end
    end

    // HI/LO output registers, loaded on the FIX->DONE edge only
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else if (r_state == ST_FIX && !i_flush) begin
            r_hi       <= w_res_hi;
            r_lo       <= w_res_lo;
            r_div_zero <= r_dz;
        end
    end

    assign o_hi       = r_hi;
    assign o_lo       = r_lo;
    assign o_div_zero = r_div_zero;

endmodule
